// File: rtl/nmr_qsw_pulse_seq.sv
// nmr_qsw_pulse_seq: programmable Q-switch damping pulse burst on each rising EN_QSW window.
// Optional NMR_QSW_ABORT_EN: EN_QSW low during a burst aborts it without a DONE strobe.
module nmr_qsw_pulse_seq #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             ADC_CLK,
  input  logic             RESET_N,
  input  logic             EN_QSW,
  input  logic [CNT_W-1:0] QSW_DLY,
  input  logic [CNT_W-1:0] QSW_WIDTH,
  input  logic [CNT_W-1:0] QSW_GAP,
  input  logic [NUM_W-1:0] QSW_NUM,
  output logic             QSW_PULSE,
  output logic             QSW_BUSY,
  output logic             QSW_DONE
);
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    DELAY = 5'b00010,
    HIGH  = 5'b00100,
    GAP   = 5'b01000,
    DONE  = 5'b10000
  } state_t;
  state_t           state;
  logic             en_d;
  logic             trig;
  logic             abort;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] w_m1;
  logic [CNT_W-1:0] g_m1;
  logic [NUM_W-1:0] rem;
  assign trig = EN_QSW & ~en_d;
`ifdef NMR_QSW_ABORT_EN
  assign abort = ~EN_QSW;
`else
  assign abort = 1'b0;
`endif
  // Width and gap are stored minus one so the HIGH/GAP counters load directly.
  // A zero-pulse burst holds DONE one extra cycle so its strobe lands one cycle after trigger.
  always_ff @(posedge ADC_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      en_d      <= 1'b0;
      cnt       <= '0;
      w_m1      <= '0;
      g_m1      <= '0;
      rem       <= '0;
      QSW_PULSE <= 1'b0;
      QSW_BUSY  <= 1'b0;
      QSW_DONE  <= 1'b0;
    end else begin
      en_d <= EN_QSW;
      if (abort && QSW_BUSY) begin
        state     <= IDLE;
        QSW_PULSE <= 1'b0;
        QSW_BUSY  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (trig) begin
            w_m1     <= (QSW_WIDTH == '0) ? '0 : QSW_WIDTH - 1'b1;
            g_m1     <= (QSW_GAP == '0) ? '0 : QSW_GAP - 1'b1;
            rem      <= QSW_NUM;
            cnt      <= QSW_DLY;
            state    <= (QSW_NUM == '0) ? DONE : DELAY;
            QSW_BUSY <= (QSW_NUM != '0);
          end
          DELAY, GAP: if (cnt == '0) begin
            state     <= HIGH;
            cnt       <= w_m1;
            QSW_PULSE <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
          HIGH: if (cnt == '0) begin
            rem       <= rem - 1'b1;
            QSW_PULSE <= 1'b0;
            state     <= (rem == NUM_W'(1)) ? DONE : GAP;
            cnt       <= g_m1;
            QSW_BUSY  <= (rem != NUM_W'(1));
            QSW_DONE  <= (rem == NUM_W'(1));
          end else begin
            cnt <= cnt - 1'b1;
          end
          DONE: begin
            QSW_DONE <= ~QSW_DONE;
            state    <= QSW_DONE ? IDLE : DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nmr_qsw_pulse_seq.sv
// tb_nmr_qsw_pulse_seq: scoreboard bench; expected {pulse,busy,done} timelines are built from burst timing.
module tb_nmr_qsw_pulse_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] dly;
  logic [15:0] wid;
  logic [15:0] gap;
  logic [7:0]  num;
  logic        pulse;
  logic        busy;
  logic        done;
  int          n_vec = 0;
  int          n_err = 0;
  logic [2:0]  q[$];

  always #5 clk = ~clk;

  nmr_qsw_pulse_seq dut (
    .ADC_CLK  (clk),
    .RESET_N  (rst_n),
    .EN_QSW   (en),
    .QSW_DLY  (dly),
    .QSW_WIDTH(wid),
    .QSW_GAP  (gap),
    .QSW_NUM  (num),
    .QSW_PULSE(pulse),
    .QSW_BUSY (busy),
    .QSW_DONE (done)
  );

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: pulse/busy/done got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    if (q.size() > 0) check(tag, {pulse, busy, done}, q.pop_front());
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // Entry i is the output expected after the i-th edge counting from the trigger edge.
  task automatic push_burst(input int d, input int w, input int g, input int n, input int abort_at);
    int we;
    int ge;
    logic [2:0] t[$];
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    if (n == 0) begin
      t.push_back(3'b000);
      t.push_back(3'b001);
    end else begin
      for (int i = 0; i <= d; i++) t.push_back(3'b010);
      for (int p = 0; p < n; p++) begin
        for (int i = 0; i < we; i++) t.push_back(3'b110);
        if (p != n - 1)
          for (int i = 0; i < ge; i++) t.push_back(3'b010);
      end
      t.push_back(3'b001);
    end
    t.push_back(3'b000);
`ifdef NMR_QSW_ABORT_EN
    if (abort_at >= 0)
      for (int i = abort_at; i < t.size(); i++) t[i] = 3'b000;
`else
    if (abort_at < -1) t.delete();
`endif
    foreach (t[i]) q.push_back(t[i]);
  endtask

  task automatic go(input int d, input int w, input int g, input int n, input int abort_at);
    dly = 16'(d);
    wid = 16'(w);
    gap = 16'(g);
    num = 8'(n);
    en  = 1'b1;
    push_burst(d, w, g, n, abort_at);
  endtask

  task automatic idle_gap(input string tag, input int n);
    en = 1'b0;
    repeat (n) q.push_back(3'b000);
    run(tag, n);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    dly   = '0;
    wid   = '0;
    gap   = '0;
    num   = '0;
    #2;
    check("reset_async", {pulse, busy, done}, 3'b000);
    repeat (3) @(negedge clk);
    check("reset_hold", {pulse, busy, done}, 3'b000);
    rst_n = 1'b1;
    idle_gap("idle", 10);

    go(3, 4, 2, 3, -1);
    run("basic", q.size());
    idle_gap("basic_tail", 1);

    go(0, 0, 0, 2, -1);
    run("degenerate", q.size());
    idle_gap("degenerate_tail", 1);

    go(5, 5, 5, 0, -1);
    run("num_zero", q.size());
    idle_gap("num_zero_tail", 1);

    go(1, 2, 1, 2, -1);
    repeat (5) q.push_back(3'b000);
    run("retrig", 2);
    wid = 16'd7;
    run("retrig_cfg", q.size());
    idle_gap("retrig_low", 1);
    go(1, 7, 1, 1, -1);
    run("retrig_new", q.size());
    idle_gap("retrig_tail", 1);

    go(3, 4, 2, 3, 12);
    run("abort_pre", 12);
    en = 1'b0;
    run("abort", q.size());
    idle_gap("abort_tail", 2);

    go(2, 5, 1, 2, -1);
    run("pre_rst", 4);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("async_rst", {pulse, busy, done}, 3'b000);
    q.delete();
    repeat (2) @(negedge clk);
    check("rst_low", {pulse, busy, done}, 3'b000);
    rst_n = 1'b1;
    idle_gap("post_rst_idle", 3);
    go(2, 5, 1, 2, -1);
    run("post_rst", q.size());
    idle_gap("post_rst_tail", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/nmr_qsw_pulse_seq.md
# nmr_qsw_pulse_seq

Q-switch pulse sequencer in the NMR acquisition path, directly downstream of the Q-switch enable window generator. It consumes the `EN_QSW` window and, on each new window, emits a programmable burst of Q-switch damping pulses on `QSW_PULSE`: a start delay, then N pulses of programmable width and gap. It reports activity (`QSW_BUSY`) and completion (`QSW_DONE`) to the sequencer/status logic. Everything runs in the `ADC_CLK` domain.

## Interface
- `CNT_W`, default 16: width of the delay, width and gap counters and their config inputs.
- `NUM_W`, default 8: width of the pulse-count input.

Ports:
- `ADC_CLK` in 1: sole clock; all logic is on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `EN_QSW` in 1: Q-switch enable window, synchronous to `ADC_CLK`.
- `QSW_DLY` in CNT_W: cycles from trigger to the first pulse. Sampled at trigger.
- `QSW_WIDTH` in CNT_W: pulse high time in cycles; 0 is treated as 1. Sampled at trigger.
- `QSW_GAP` in CNT_W: low time between pulses in cycles; 0 is treated as 1. Sampled at trigger.
- `QSW_NUM` in NUM_W: pulses per burst. Sampled at trigger.
- `QSW_PULSE` out 1: Q-switch drive, registered, active high.
- `QSW_BUSY` out 1: high in every state except IDLE and DONE.
- `QSW_DONE` out 1: one-cycle strobe when a burst completes normally.

## Operation
- **Trigger**
  - Trigger = `EN_QSW & ~en_d`, where `en_d` is `EN_QSW` registered.
  - A trigger is acted on only in IDLE.
  - `EN_QSW` must fall and rise again to retrigger.
- **Configuration capture**
  - At the trigger edge, DLY, max(WIDTH,1), max(GAP,1) and NUM are latched into internal registers.
  - Config input changes mid-burst have no effect.
- **FSM states (one-hot)**
  - **IDLE**
    - On trigger with NUM=0: go to DONE.
    - On trigger with NUM≠0: go to DELAY, cnt=DLY.
  - **DELAY**
    - If cnt=0: go to HIGH, cnt=W−1, remaining=NUM.
    - Otherwise: cnt−1.
  - **HIGH**
    - `QSW_PULSE`=1.
    - When cnt=0, remaining−1:
      - if the new remaining value is 0, go to DONE;
      - otherwise go to GAP, cnt=G−1.
  - **GAP**
    - `QSW_PULSE`=0.
    - When cnt=0: go to HIGH, cnt=W−1.
  - **DONE**
    - `QSW_DONE`=1 for exactly one cycle, then IDLE.
- **Outputs**
  - `QSW_PULSE` is registered, glitch-free, and high only in HIGH.
  - `QSW_BUSY` = state ∈ {DELAY, HIGH, GAP}.
- **Counter rules**
  - Counters are unsigned CNT_W and never wrap.
  - Each decrement is guarded by the cnt=0 test.
  - All-ones values are legal: 2^CNT_W−1 for delay, width and gap.
- **Reset**
  - All outputs are 0, state=IDLE, and `en_d`=0.
  - If `EN_QSW` is already high when reset releases, the first clock sees a rising edge, so a burst starts. This is intentional.
  - Reset mid-burst drops `QSW_PULSE` asynchronously and immediately.

## Timing
- Let edge k be the first edge sampling `EN_QSW`=1 after a 0.
- `QSW_PULSE` rises after edge k+DLY+1. Delay from trigger to pulse = DLY+1 cycles (1 cycle minimum).
- Pulse high = max(WIDTH,1) cycles. Low between pulses = max(GAP,1) cycles.
- `QSW_DONE` is asserted in the cycle immediately after the last pulse's falling edge.
- `QSW_BUSY` is asserted from edge k to the edge on which the FSM enters DONE.
- With NUM=0, `QSW_DONE` is asserted after edge k+1 and there is no pulse.
- Minimum re-arm time: IDLE is reached one cycle after DONE. A trigger arriving while not in IDLE is lost, not queued.

## Configuration
- **Macro `NMR_QSW_ABORT_EN`**
  - Defined:
    - `EN_QSW`=0 sampled in DELAY, HIGH or GAP forces IDLE at that edge.
    - `QSW_PULSE` is 0 after the same edge.
    - No `QSW_DONE` is issued.
    - Aborts are not counted.
  - Undefined:
    - The burst always runs to completion regardless of `EN_QSW`.
    - `QSW_DONE` is always issued.

## Test plan
- **Reset:** `RESET_N` low with `EN_QSW`=0 → `QSW_PULSE`/`QSW_BUSY`/`QSW_DONE`=0. Release, hold 10 cycles → no activity.
- **Basic burst:** DLY=3, WIDTH=4, GAP=2, NUM=3, `EN_QSW` rises and stays high. Required response:
  - pulses high in cycles k+4..k+7, k+10..k+13 and k+16..k+19;
  - `QSW_DONE` for one cycle at k+20;
  - `QSW_BUSY` low from k+20.
- **Degenerate values:**
  - DLY=0, WIDTH=0, GAP=0, NUM=2 → pulses at k+1 and k+3, each 1 cycle.
  - NUM=0 → `QSW_DONE` at k+1 with no pulse and `QSW_BUSY` never high.
- **Retrigger and config change:** hold `EN_QSW` high through DONE → no second burst. Change WIDTH mid-burst → width unchanged. Toggle `EN_QSW` 0→1 → new burst uses the new values.
- **Abort:** with `NMR_QSW_ABORT_EN`, drop `EN_QSW` in the middle of the 2nd pulse of the basic burst → `QSW_PULSE` 0 the next cycle, state IDLE, no `QSW_DONE`. Without the macro → identical to the full basic burst.
- **Async reset mid-pulse:** assert `RESET_N` low while `QSW_PULSE`=1 → `QSW_PULSE` falls without waiting for a clock edge. After release → IDLE, and the next trigger gives a normal burst.
